// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned TAG_W = 2;

    typedef enum logic [2:0] {
        SERVE,
        DUMP_WAIT,
        DUMP_ISSUE,
        DUMP_DRAIN,
        DUMP_DONE
    } arb_state_t;

    localparam logic [TAG_W-1:0] TAG_IF   = 2'd0;
    localparam logic [TAG_W-1:0] TAG_DM   = 2'd1;
    localparam logic [TAG_W-1:0] TAG_DUMP = 2'd2;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Read-tag shift register: follows each RAM read for RD_LAT cycles so the
// returning data can be steered to the port (or dump stream) that issued it.
module mem_rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [ADDR_W-1:0] out_addr,
    output logic              empty_c
);

    logic [RD_LAT-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [RD_LAT];
    logic [ADDR_W-1:0] addr_q [RD_LAT];

    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            addr_q[0]  <= in_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_tag   = tag_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];
    assign empty_c   = ~|valid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: DM has fixed priority over IF, plus a halt-time
// sequencer that streams every RAM word out once the CPU has stopped.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned DUMP_WORDS = 512
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] dump_cnt;
    logic              issue_valid_c;
    logic [TAG_W-1:0]  issue_tag_c;
    logic              pipe_valid;
    logic [TAG_W-1:0]  pipe_tag;
    logic [ADDR_W-1:0] pipe_addr;
    logic              pipe_empty_c;
    logic              exit_if_c;
    logic              exit_dm_c;
    logic              exit_dump_c;

    // Grant and RAM drive: at most one access per cycle, DM wins in SERVE.
    always_comb begin
        dm_gnt        = 1'b0;
        if_gnt        = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        issue_valid_c = 1'b0;
        issue_tag_c   = TAG_IF;
        if (state == SERVE) begin
            dm_gnt = dm_req;
            if_gnt = if_req & ~dm_req;
            if (dm_req) begin
                mem_en        = 1'b1;
                mem_we        = dm_we;
                mem_addr      = dm_addr;
                mem_wdata     = dm_wdata;
                issue_valid_c = ~dm_we;
                issue_tag_c   = TAG_DM;
            end else if (if_req) begin
                mem_en        = 1'b1;
                mem_addr      = if_addr;
                issue_valid_c = 1'b1;
                issue_tag_c   = TAG_IF;
            end
        end else if (state == DUMP_ISSUE) begin
            mem_en        = 1'b1;
            mem_addr      = dump_cnt;
            issue_valid_c = 1'b1;
            issue_tag_c   = TAG_DUMP;
        end
    end

    mem_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_tag_pipe (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (issue_valid_c),
        .in_tag    (issue_tag_c),
        .in_addr   (mem_addr),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_addr  (pipe_addr),
        .empty_c   (pipe_empty_c)
    );

    assign exit_if_c   = pipe_valid && (pipe_tag == TAG_IF);
    assign exit_dm_c   = pipe_valid && (pipe_tag == TAG_DM);
    assign exit_dump_c = pipe_valid && (pipe_tag == TAG_DUMP);

    // Sequencer state plus registered read-return and dump outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= SERVE;
            dump_cnt   <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rvalid  <= 1'b0;
            dm_rdata   <= '0;
            dump_busy  <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            if_rvalid  <= exit_if_c;
            dm_rvalid  <= exit_dm_c;
            dump_valid <= exit_dump_c;
            if (exit_if_c) if_rdata <= mem_rdata;
            if (exit_dm_c) dm_rdata <= mem_rdata;
            if (exit_dump_c) begin
                dump_addr <= pipe_addr;
                dump_data <= mem_rdata;
            end
            case (state)
                SERVE: begin
                    if (dump_start) begin
                        state     <= DUMP_WAIT;
                        dump_busy <= 1'b1;
                    end
                end
                DUMP_WAIT: begin
                    if (pipe_empty_c) state <= DUMP_ISSUE;
                end
                DUMP_ISSUE: begin
                    // Hold the counter on the final address so it never wraps.
                    if (dump_cnt == LAST_ADDR) state <= DUMP_DRAIN;
                    else dump_cnt <= dump_cnt + ADDR_W'(1);
                end
                DUMP_DRAIN: begin
                    if (exit_dump_c && (pipe_addr == LAST_ADDR)) begin
                        state     <= DUMP_DONE;
                        dump_busy <= 1'b0;
                        dump_done <= 1'b1;
                    end
                end
                DUMP_DONE: state <= DUMP_DONE;
                default:   state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural RAM and
// a shadow-memory reference model.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned DUMP_WORDS = 512;
    localparam int unsigned DEPTH      = 2 ** ADDR_W;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dump_start = 1'b0;
    logic              dump_busy;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .DUMP_WORDS(DUMP_WORDS)
    ) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference state
    typedef struct {
        logic [DATA_W-1:0] data;
        int unsigned       cyc;
    } exp_t;

    logic [DATA_W-1:0] shadow [DEPTH];
    exp_t              if_q[$];
    exp_t              dm_q[$];
    logic [DATA_W-1:0] exp_if_rdata = '0;
    logic [DATA_W-1:0] exp_dm_rdata = '0;
    bit                in_serve = 1'b1;
    bit                dump_armed = 1'b0;
    bit                mon_en = 1'b0;
    bit                preload = 1'b1;
    int unsigned       exp_dump_next = 0;
    int unsigned       last_dump_cyc = 0;
    int                checks = 0;
    int                errors = 0;

    // Behavioural single-port RAM with RD_LAT read latency
    logic [DATA_W-1:0] ram      [DEPTH];
    logic [DATA_W-1:0] ram_pipe [RD_LAT];
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= shadow[i];
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        ram_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : DATA_W'($urandom);
        for (int i = 1; i < int'(RD_LAT); i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_rdata = ram_pipe[RD_LAT-1];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive at negedge, check combinational grants, record expectations.
    task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                        input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] dd, input logic ds);
        logic eif, edm;
        exp_t e;
        @(negedge CLK);
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        dump_start = ds;
        #1;
        edm = in_serve & dr;
        eif = in_serve & ir & ~dr;
        chk(dm_gnt == edm, "dm_gnt", 32'(dm_gnt), 32'(edm));
        chk(if_gnt == eif, "if_gnt", 32'(if_gnt), 32'(eif));
        if (edm && dw) begin
            shadow[da] = dd;
        end else if (edm) begin
            e.data = shadow[da]; e.cyc = cyc + RD_LAT + 1;
            dm_q.push_back(e);
        end
        if (eif) begin
            e.data = shadow[ia]; e.cyc = cyc + RD_LAT + 1;
            if_q.push_back(e);
        end
        if (ds && in_serve) begin
            in_serve   = 1'b0;
            dump_armed = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        return ($urandom % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
    endfunction

    // Monitor: compares every DUT response against the scoreboard queues.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                if (if_q.size() > 0) begin
                    chk(if_q[0].cyc >= cyc, "if_missing", cyc, if_q[0].cyc);
                    if (if_q[0].cyc < cyc) void'(if_q.pop_front());
                end
                if (if_rvalid) begin
                    chk(if_q.size() > 0, "if_spurious", 32'(if_q.size()), 32'd1);
                    if (if_q.size() > 0) begin
                        e = if_q.pop_front();
                        chk(e.cyc == cyc, "if_latency", cyc, e.cyc);
                        chk(if_rdata == e.data, "if_rdata", if_rdata, e.data);
                        exp_if_rdata = e.data;
                    end
                end else begin
                    chk(if_rdata == exp_if_rdata, "if_hold", if_rdata, exp_if_rdata);
                end
                if (dm_q.size() > 0) begin
                    chk(dm_q[0].cyc >= cyc, "dm_missing", cyc, dm_q[0].cyc);
                    if (dm_q[0].cyc < cyc) void'(dm_q.pop_front());
                end
                if (dm_rvalid) begin
                    chk(dm_q.size() > 0, "dm_spurious", 32'(dm_q.size()), 32'd1);
                    if (dm_q.size() > 0) begin
                        e = dm_q.pop_front();
                        chk(e.cyc == cyc, "dm_latency", cyc, e.cyc);
                        chk(dm_rdata == e.data, "dm_rdata", dm_rdata, e.data);
                        exp_dm_rdata = e.data;
                    end
                end else begin
                    chk(dm_rdata == exp_dm_rdata, "dm_hold", dm_rdata, exp_dm_rdata);
                end
                if (dump_valid) begin
                    chk(dump_armed, "dump_unarmed", 32'(dump_valid), 32'd0);
                    chk(exp_dump_next < DUMP_WORDS, "dump_extra", exp_dump_next, DUMP_WORDS);
                    chk(dump_addr == ADDR_W'(exp_dump_next), "dump_addr", 32'(dump_addr), exp_dump_next);
                    chk(dump_data == shadow[exp_dump_next % DEPTH], "dump_data",
                        dump_data, shadow[exp_dump_next % DEPTH]);
                    if (exp_dump_next == 0)
                        chk(if_q.size() == 0 && dm_q.size() == 0, "dump_before_drain",
                            32'(if_q.size() + dm_q.size()), 32'd0);
                    else
                        chk(last_dump_cyc + 1 == cyc, "dump_gap", cyc, last_dump_cyc + 1);
                    if (exp_dump_next + 1 < DUMP_WORDS)
                        chk(dump_busy && !dump_done, "dump_busy_mid", {dump_busy, dump_done}, 32'h2);
                    exp_dump_next++;
                    last_dump_cyc = cyc;
                end
                chk(!(dump_busy && dump_done), "busy_done_excl", {dump_busy, dump_done}, 32'h0);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = DATA_W'($urandom);
        shadow[5] = 32'hDEAD_BEEF;
        repeat (3) @(negedge CLK);
        preload = 1'b0;
        reset   = 1'b0;
        chk(if_rvalid == 0 && dm_rvalid == 0, "rst_rvalid", {if_rvalid, dm_rvalid}, 32'h0);
        chk(if_rdata == 0, "rst_if_rdata", if_rdata, 32'h0);
        chk(dm_rdata == 0, "rst_dm_rdata", dm_rdata, 32'h0);
        chk(dump_busy == 0 && dump_valid == 0 && dump_done == 0, "rst_dump_flags",
            {dump_busy, dump_valid, dump_done}, 32'h0);
        chk(dump_addr == 0 && dump_data == 0, "rst_dump_bus", dump_data, 32'h0);
        mon_en = 1'b1;

        // Lone fetch of the preloaded word
        step(1'b1, 9'd5, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);
        // DM write wins over IF, IF granted the next cycle, then read back
        step(1'b1, 9'd3, 1'b1, 1'b1, 9'd7, 32'h1234, 1'b0);
        step(1'b1, 9'd3, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 9'd7, '0, 1'b0);
        idle(3);
        // Alternating DM/IF reads back to back
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b0, '0, 1'b1, 1'b0, 9'd2, '0, 1'b0);
            else            step(1'b1, 9'd4, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        idle(3);
        // Random mixed traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), rnd_addr(), 1'($urandom), 1'($urandom), rnd_addr(),
                 DATA_W'($urandom), 1'b0);
        idle(5);
        chk(if_q.size() == 0 && dm_q.size() == 0, "traffic_drained",
            32'(if_q.size() + dm_q.size()), 32'h0);

        // Start a dump and reset it when address 200 is streaming
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(1);
        found = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge CLK);
            if (dump_valid && dump_addr == 9'd200) begin
                found = 1'b1;
                break;
            end
        end
        chk(found, "wait_addr200", 32'(found), 32'h1);
        reset = 1'b1;
        in_serve = 1'b1; dump_armed = 1'b0; exp_dump_next = 0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        if_q.delete(); dm_q.delete();
        @(posedge CLK);
        #1;
        chk(dump_busy == 0 && dump_valid == 0 && dump_done == 0, "midreset_flags",
            {dump_busy, dump_valid, dump_done}, 32'h0);
        @(negedge CLK);
        reset = 1'b0;

        // Dump started alongside an in-flight DM read; a second start is ignored
        step(1'b0, '0, 1'b1, 1'b0, 9'd5, '0, 1'b1);
        idle(1);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (dump_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk(found, "wait_dump_issue", 32'(found), 32'h1);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(1);
        for (int n = 0; n < 2000 && exp_dump_next < DUMP_WORDS; n++) @(negedge CLK);
        chk(exp_dump_next == DUMP_WORDS, "dump_complete", exp_dump_next, DUMP_WORDS);
        idle(3);
        chk(dump_done == 1 && dump_busy == 0, "done_state", {dump_busy, dump_done}, 32'h1);
        for (int i = 0; i < 5; i++) step(1'b1, 9'd5, 1'($urandom), 1'b0, 9'd6, '0, 1'b0);
        idle(20);
        chk(exp_dump_next == DUMP_WORDS, "dump_count", exp_dump_next, DUMP_WORDS);
        chk(dump_done == 1, "done_held", 32'(dump_done), 32'h1);
        chk(if_q.size() == 0 && dm_q.size() == 0, "final_drained",
            32'(if_q.size() + dm_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
